// File: rtl/vdma_pkg.sv
// Shared types and defaults for the video DMA frame-buffer scheduling logic.
package vdma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } fb_state_t;

    localparam int          FB_IDX_W         = 3;
    localparam logic [31:0] DEF_BASE_ADDR    = 32'h1000_0000;
    localparam logic [31:0] DEF_FRAME_STRIDE = 32'h0012_C000;  // 640x480x4 bytes

endpackage

// File: rtl/fb_next_index.sv
// Combinational ring scan: first buffer index after cur (mod NUM_FRAMES)
// that is neither avoid_a nor avoid_b.
module fb_next_index
    import vdma_pkg::*;
#(
    parameter int NUM_FRAMES = 3
) (
    input  logic [FB_IDX_W-1:0] cur,
    input  logic [FB_IDX_W-1:0] avoid_a,
    input  logic [FB_IDX_W-1:0] avoid_b,
    output logic [FB_IDX_W-1:0] nxt
);

    logic [FB_IDX_W-1:0] cand;
    logic                found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        nxt   = cur;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_FRAMES; k++) begin
            cand = FB_IDX_W'((int'(cur) + k) % NUM_FRAMES);
            if (!found && (cand != avoid_a) && (cand != avoid_b)) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer index scheduler between the VDMA writer and reader.
// Optional saturating drop/repeat statistics when FB_ARB_STATS_EN is defined.
module fb_arbiter
    import vdma_pkg::*;
#(
    parameter int                NUM_FRAMES   = 3,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(DEF_BASE_ADDR),
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(DEF_FRAME_STRIDE)
`ifdef FB_ARB_STATS_EN
    ,
    parameter int                CNT_W        = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                freeze,
    input  logic                wr_frame_start,
    input  logic                wr_frame_done,
    input  logic                rd_frame_start,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_base_addr,
    output logic [ADDR_W-1:0]   rd_base_addr,
    output logic [FB_IDX_W-1:0] wr_idx,
    output logic [FB_IDX_W-1:0] rd_idx,
    output fb_state_t           state,
    output logic                frame_valid
`ifdef FB_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic [CNT_W-1:0]    repeat_cnt
`endif
);

    localparam logic [FB_IDX_W-1:0] RST_RD_IDX = FB_IDX_W'(NUM_FRAMES - 1);

    function automatic logic [ADDR_W-1:0] addr_of(input logic [FB_IDX_W-1:0] idx);
        return ADDR_W'(64'(BASE_ADDR) + 64'(idx) * 64'(FRAME_STRIDE));
    endfunction

    fb_state_t           state_d;
    logic [FB_IDX_W-1:0] latest_idx;
    logic                latest_valid;

    logic                commit;
    logic                pending;
    logic                swap;
    logic [FB_IDX_W-1:0] latest_d;
    logic [FB_IDX_W-1:0] rd_d;
    logic [FB_IDX_W-1:0] wr_d;
    logic [FB_IDX_W-1:0] wr_scan;
    logic                latest_valid_d;

    // Commit is applied before the reader swap, so a simultaneous reader
    // picks up the frame that completes in the same cycle.
    always_comb begin
        commit         = wr_frame_done && (state == RUN);
        latest_d       = commit ? wr_idx : latest_idx;
        pending        = commit || latest_valid;
        swap           = rd_frame_start && pending;
        rd_d           = swap ? latest_d : rd_idx;
        latest_valid_d = pending && !swap;
        wr_d           = commit ? wr_scan : wr_idx;
    end

    fb_next_index #(
        .NUM_FRAMES (NUM_FRAMES)
    ) u_next_index (
        .cur     (wr_idx),
        .avoid_a (rd_d),
        .avoid_b (latest_d),
        .nxt     (wr_scan)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (wr_frame_start && enable) state_d = RUN;
            end
            RUN: begin
                // enable=0 wins over freeze: writing stops entirely.
                if (wr_frame_done) begin
                    if (!enable)     state_d = IDLE;
                    else if (freeze) state_d = FREEZE;
                end
            end
            FREEZE: begin
                if (!enable)                        state_d = IDLE;
                else if (wr_frame_start && !freeze) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx       <= '0;
            rd_idx       <= RST_RD_IDX;
            latest_idx   <= '0;
            latest_valid <= 1'b0;
            frame_valid  <= 1'b0;
            wr_en        <= 1'b0;
            wr_base_addr <= addr_of('0);
            rd_base_addr <= addr_of(RST_RD_IDX);
        end else begin
            wr_idx       <= wr_d;
            rd_idx       <= rd_d;
            latest_idx   <= latest_d;
            latest_valid <= latest_valid_d;
            frame_valid  <= frame_valid || commit;
            wr_en        <= (state_d == RUN);
            wr_base_addr <= addr_of(wr_d);
            rd_base_addr <= addr_of(rd_d);
        end
    end

`ifdef FB_ARB_STATS_EN
    logic drop_ev;
    logic repeat_ev;

    always_comb begin
        drop_ev   = commit && latest_valid;
        repeat_ev = rd_frame_start && !pending && frame_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt   <= '0;
            repeat_cnt <= '0;
        end else begin
            if (drop_ev && (drop_cnt != '1))     drop_cnt   <= drop_cnt + 1'b1;
            if (repeat_ev && (repeat_cnt != '1)) repeat_cnt <= repeat_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed steps then random traffic
// against a buffer-role reference model.
module tb_fb_arbiter;

    localparam int          N      = 3;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0012_C000;
    localparam int          M_IDLE = 0, M_RUN = 1, M_FREEZE = 2;

    logic        clk = 1'b0;
    logic        rst, enable, freeze;
    logic        wr_frame_start, wr_frame_done, rd_frame_start;
    logic        wr_en, frame_valid;
    logic [31:0] wr_base_addr, rd_base_addr;
    logic [2:0]  wr_idx, rd_idx;
    logic [1:0]  state;
`ifdef FB_ARB_STATS_EN
    logic [15:0] drop_cnt, repeat_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: which buffer each role owns, plus mode and statistics.
    int m_wr, m_rd, m_latest, m_mode, m_drop, m_rep;
    bit m_lv, m_fv;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .freeze         (freeze),
        .wr_frame_start (wr_frame_start),
        .wr_frame_done  (wr_frame_done),
        .rd_frame_start (rd_frame_start),
        .wr_en          (wr_en),
        .wr_base_addr   (wr_base_addr),
        .rd_base_addr   (rd_base_addr),
        .wr_idx         (wr_idx),
        .rd_idx         (rd_idx),
        .state          (state),
        .frame_valid    (frame_valid)
`ifdef FB_ARB_STATS_EN
        ,
        .drop_cnt       (drop_cnt),
        .repeat_cnt     (repeat_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr(input int idx);
        return BASE + 32'(idx) * STRIDE;
    endfunction

    // First buffer after 'from' around the ring that neither the reader
    // nor the pending frame holds.
    function automatic int free_after(input int from, input int a, input int b);
        for (int k = 1; k <= N; k++) begin
            if (((from + k) % N != a) && ((from + k) % N != b)) return (from + k) % N;
        end
        return from;
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = N - 1; m_latest = 0; m_mode = M_IDLE;
        m_lv = 1'b0; m_fv = 1'b0; m_drop = 0; m_rep = 0;
    endtask

    task automatic model_update(input bit r, input bit en, input bit frz,
                                input bit ws, input bit wd, input bit rs);
        bit committed;
        if (r) begin
            model_reset();
            return;
        end
        committed = wd && (m_mode == M_RUN);
        if (committed) begin
            if (m_lv && m_drop < 16'hFFFF) m_drop++;
            m_latest = m_wr;
            m_lv     = 1'b1;
            m_fv     = 1'b1;
        end
        if (rs) begin
            if (m_lv) begin
                m_rd = m_latest;
                m_lv = 1'b0;
            end else if (m_fv && m_rep < 16'hFFFF) begin
                m_rep++;
            end
        end
        if (committed) m_wr = free_after(m_wr, m_rd, m_latest);
        case (m_mode)
            M_IDLE:   if (ws && en) m_mode = M_RUN;
            M_RUN:    if (wd) m_mode = !en ? M_IDLE : (frz ? M_FREEZE : M_RUN);
            default:  if (!en) m_mode = M_IDLE;
                      else if (ws && !frz) m_mode = M_RUN;
        endcase
    endtask

    task automatic check_all();
        check("wr_en",        64'(wr_en),        64'(m_mode == M_RUN));
        check("wr_idx",       64'(wr_idx),       64'(m_wr));
        check("rd_idx",       64'(rd_idx),       64'(m_rd));
        check("wr_base_addr", 64'(wr_base_addr), 64'(addr(m_wr)));
        check("rd_base_addr", 64'(rd_base_addr), 64'(addr(m_rd)));
        check("state",        64'(state),        64'(m_mode));
        check("frame_valid",  64'(frame_valid),  64'(m_fv));
`ifdef FB_ARB_STATS_EN
        check("drop_cnt",     64'(drop_cnt),     64'(m_drop));
        check("repeat_cnt",   64'(repeat_cnt),   64'(m_rep));
`endif
    endtask

    // Drive one cycle of inputs, clock it, then compare outputs #1 after the edge.
    task automatic step(input bit r, input bit en, input bit frz,
                        input bit ws, input bit wd, input bit rs);
        rst = r; enable = en; freeze = frz;
        wr_frame_start = ws; wr_frame_done = wd; rd_frame_start = rs;
        @(posedge clk);
        model_update(r, en, frz, ws, wd, rs);
        #1;
        rst = 1'b0; wr_frame_start = 1'b0; wr_frame_done = 1'b0; rd_frame_start = 1'b0;
        check_all();
    endtask

    initial begin
        int  rd_hold;
        int  rep_base;
        bit  r, en, frz, ws, wd, rs;

        rst = 1'b1; enable = 1'b0; freeze = 1'b0;
        wr_frame_start = 1'b0; wr_frame_done = 1'b0; rd_frame_start = 1'b0;
        model_reset();

        // Reset state.
        step(1, 0, 0, 0, 0, 0);
        check("rst_wr_idx", 64'(wr_idx), 64'd0);
        check("rst_rd_idx", 64'(rd_idx), 64'd2);
        check("rst_state",  64'(state),  64'd0);

        // Start of frame -> RUN.
        step(0, 1, 0, 1, 0, 0);
        check("start_wr_en",   64'(wr_en),        64'd1);
        check("start_rd_addr", 64'(rd_base_addr), 64'h1025_8000);

        // Commit, swap, commit.
        step(0, 1, 0, 0, 1, 0);
        check("commit1_wr_idx", 64'(wr_idx), 64'd1);
        step(0, 1, 0, 0, 0, 1);
        check("swap_rd_idx",  64'(rd_idx),       64'd0);
        check("swap_rd_addr", 64'(rd_base_addr), 64'h1000_0000);
        step(0, 1, 0, 0, 1, 0);
        check("commit2_wr_idx",  64'(wr_idx),       64'd2);
        check("commit2_wr_addr", 64'(wr_base_addr), 64'h1025_8000);

        // Simultaneous commit and reader start at wr=2/rd=0/latest=1.
        step(0, 1, 0, 0, 1, 1);
        check("simul_rd_idx", 64'(rd_idx), 64'd2);
        check("simul_wr_idx", 64'(wr_idx), 64'd0);
        // latest_valid ended 0: a further reader start repeats buffer 2.
        step(0, 1, 0, 0, 0, 1);
        check("simul_repeat_rd_idx", 64'(rd_idx), 64'd2);

        // Freeze: completing frame commits, writer stops, reader repeats.
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0);
        check("freeze_state", 64'(state), 64'd2);
        check("freeze_wr_en", 64'(wr_en), 64'd0);
        rep_base = m_rep;
        step(0, 1, 1, 0, 0, 1);
        rd_hold = m_rd;
        check("freeze_swap_rd", 64'(rd_idx), 64'd0);
        step(0, 1, 1, 0, 0, 1);
        check("freeze_hold_rd1", 64'(rd_idx), 64'(rd_hold));
        step(0, 1, 1, 0, 0, 1);
        check("freeze_hold_rd2", 64'(rd_idx), 64'(rd_hold));
`ifdef FB_ARB_STATS_EN
        check("freeze_repeats", 64'(repeat_cnt), 64'(rep_base + 2));
`endif
        step(0, 1, 0, 1, 0, 0);
        check("unfreeze_state", 64'(state), 64'd1);

        // Reset mid-frame, then a stray done in IDLE is ignored.
        step(1, 1, 0, 0, 0, 0);
        check("midrst_state",  64'(state),       64'd0);
        check("midrst_fvalid", 64'(frame_valid), 64'd0);
        check("midrst_rd_idx", 64'(rd_idx),      64'd2);
        step(0, 1, 0, 0, 1, 0);
        check("idle_done_wr_idx", 64'(wr_idx), 64'd0);

        // Fast writer: two commits with no reader pulse -> one drop.
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        check("fast_wr_idx1", 64'(wr_idx), 64'd1);
        step(0, 1, 0, 0, 1, 0);
        check("fast_wr_idx2", 64'(wr_idx), 64'd0);
        check("fast_rd_idx",  64'(rd_idx), 64'd2);
`ifdef FB_ARB_STATS_EN
        check("fast_drop", 64'(drop_cnt), 64'd1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 79) == 0);
            en  = ($urandom_range(0, 15) != 0);
            frz = ($urandom_range(0, 3) == 0);
            ws  = ($urandom_range(0, 3) == 0);
            wd  = ($urandom_range(0, 3) == 0);
            rs  = ($urandom_range(0, 3) == 0);
            step(r, en, frz, ws, wd, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
